// File: rtl/iomem_router_if.sv
// PicoSoC iomem bus bundle: the CPU-facing request/response pair plus the
// peripheral-facing per-slot request lines, with shared address/data.
//
// Handshake: a request is offered by holding valid high with stable
// address/strobes/data. It completes on the single cycle in which ready is
// high, and the requester drops valid on the clock edge that samples ready.
interface iomem_router_if #(
    parameter int NUM_SLOTS = 4
);
    logic                    m_valid;
    logic                    m_ready;
    logic [3:0]              m_wstrb;
    logic [31:0]             m_addr;
    logic [31:0]             m_wdata;
    logic [31:0]             m_rdata;
    logic [NUM_SLOTS-1:0]    s_valid;
    logic [NUM_SLOTS-1:0]    s_ready;
    logic [NUM_SLOTS*32-1:0] s_rdata;
    logic [3:0]              s_wstrb;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;

    // Router side: answers the CPU, drives the peripherals.
    modport slave (
        input  m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
    );

    // Environment side: the CPU and the peripherals around the router.
    modport master (
        output m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
    );
endinterface

// File: rtl/iomem_router.sv
// iomem_router: decodes a CPU iomem request into one of NUM_SLOTS peripheral
// pages, forwards a registered request to the selected slot and returns its
// response. Unmapped pages and slots that never answer within TIMEOUT_CYCLES
// are terminated with ERR_RDATA, an err_irq pulse and an error record.
// Every output is a flop; nothing combinational reaches an output pin.
module iomem_router #(
    parameter int          NUM_SLOTS      = 4,
    parameter logic [7:0]  BASE_PAGE      = 8'h03,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    iomem_router_if.slave     bus,
    output logic              err_irq,
    output logic [31:0]       err_addr,
    output logic [7:0]        err_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERROR  = 2'd3
    } state_t;

    localparam logic [7:0] SLOTS_B = 8'(NUM_SLOTS);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  m_ready_q, m_ready_d;
    logic [31:0]           m_rdata_q, m_rdata_d;
    logic [NUM_SLOTS-1:0]  s_valid_q, s_valid_d;
    logic [3:0]            s_wstrb_q, s_wstrb_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [31:0]           s_wdata_q, s_wdata_d;
    logic                  err_irq_q, err_irq_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [7:0]            page;
    logic                  hit;
    logic [NUM_SLOTS-1:0]  page_onehot;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;

    // Page arithmetic is 8-bit so addresses below BASE_PAGE wrap high and miss.
    assign page = bus.m_addr[31:24] - BASE_PAGE;
    assign hit  = (page < SLOTS_B);

    // One-hot slot select for a fresh request; all-zero on a miss.
    always_comb begin
        page_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            page_onehot[i] = (page == 8'(i));
        end
    end

    // The registered s_valid already marks the selected slot, so masking with
    // it both picks that slot's ready and ignores every other slot's ready.
    assign sel_ready = |(bus.s_ready & s_valid_q);

    // Read data mux steered by the registered one-hot select.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (s_valid_q[i]) begin
                sel_rdata = sel_rdata | bus.s_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and next-output logic; every output flop gets its value here.
    always_comb begin
        state_d     = state_q;
        s_valid_d   = s_valid_q;
        s_wstrb_d   = s_wstrb_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        m_rdata_d   = '0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    s_addr_d  = bus.m_addr;
                    s_wstrb_d = bus.m_wstrb;
                    s_wdata_d = bus.m_wdata;
                    if (hit) begin
                        s_valid_d = page_onehot;
                        state_d   = ACCESS;
                    end else begin
                        m_rdata_d = ERR_RDATA;
                        state_d   = ERROR;
                    end
                end
            end
            ACCESS: begin
                // A ready in the timeout cycle still completes normally.
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    s_valid_d = '0;
                    cnt_d     = '0;
                    state_d   = RESP;
                end else if (cnt_q == TO_LAST) begin
                    m_rdata_d = ERR_RDATA;
                    s_valid_d = '0;
                    cnt_d     = '0;
                    state_d   = ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            ERROR: begin
                err_addr_d = s_addr_q;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
                state_d = IDLE;
            end
            default: begin
                s_valid_d = '0;
                state_d   = IDLE;
            end
        endcase

        // Response strobes are high exactly while sitting in RESP or ERROR.
        m_ready_d = (state_d == RESP) || (state_d == ERROR);
        err_irq_d = (state_d == ERROR);
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= '0;
            s_valid_q   <= '0;
            s_wstrb_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            m_ready_q   <= m_ready_d;
            m_rdata_q   <= m_rdata_d;
            s_valid_q   <= s_valid_d;
            s_wstrb_q   <= s_wstrb_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign err_irq     = err_irq_q;
    assign err_addr    = err_addr_q;
    assign err_count   = err_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_iomem_router.sv
// Testbench for iomem_router: directed accesses with hand-computed responses,
// a scoreboard queue filled at issue time and drained by a response monitor.
module tb_iomem_router;

    localparam int          NUM_SLOTS = 4;
    localparam int          TO        = 8;
    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_irq;
    logic [31:0] err_addr;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    iomem_router_if #(.NUM_SLOTS(NUM_SLOTS)) bus ();

    iomem_router #(
        .NUM_SLOTS      (NUM_SLOTS),
        .BASE_PAGE      (8'h03),
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR_RDATA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_irq   (err_irq),
        .err_addr  (err_addr),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // ---------------- peripheral model ----------------
    // ready_after[i]: cycles of s_valid before ready (0 = same cycle, -1 = never).
    int          ready_after [NUM_SLOTS];
    int          hold_cnt    [NUM_SLOTS];
    logic [3:0]  force_ready;

    assign bus.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0BAD_F00D};

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (reset) hold_cnt[i] <= 0;
            else       hold_cnt[i] <= bus.s_valid[i] ? hold_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        bus.s_ready = force_ready;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.s_valid[i] && ready_after[i] >= 0 && hold_cnt[i] >= ready_after[i])
                bus.s_ready[i] = 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    int          resp_seen = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic        prev_ready = 1'b0;
    logic [7:0]  exp_err_count = 8'd0;
    logic [31:0] exp_err_addr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Response monitor: pops one expectation per m_ready pulse.
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b0;
        end else begin
            if (prev_ready && !bus.m_ready) check("m_rdata_clear", bus.m_rdata, 32'd0);
            if (bus.s_valid != '0) check("s_valid_onehot", $countones(bus.s_valid), 32'd1);
            if (bus.m_ready) begin
                resp_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_m_ready: got m_ready=1 rdata=%h, want no response", bus.m_rdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("m_rdata", bus.m_rdata, mon_e[31:0]);
                    check("err_irq", {31'd0, err_irq}, {31'd0, mon_e[32]});
                end
            end else begin
                check("err_irq_idle", {31'd0, err_irq}, 32'd0);
            end
            prev_ready = bus.m_ready;
        end
    end

    // ---------------- driver ----------------
    task automatic do_access(input string name, input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input logic exp_err, input logic [31:0] exp_rdata,
                             input int exp_lat, input int exp_vcyc, input logic [3:0] exp_mask);
        int         n;
        int         vcyc;
        logic [3:0] seen;
        logic       got;
        n = 0; vcyc = 0; seen = '0; got = 1'b0;
        @(posedge clk); #1;
        bus.m_valid = 1'b1;
        bus.m_addr  = addr;
        bus.m_wstrb = wstrb;
        bus.m_wdata = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        if (exp_err) begin
            exp_err_addr = addr;
            if (exp_err_count != 8'hFF) exp_err_count = exp_err_count + 8'd1;
        end
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.s_valid != '0) begin
                vcyc++;
                seen = seen | bus.s_valid;
                check({name, "_s_addr"}, bus.s_addr, addr);
                check({name, "_s_wdata"}, bus.s_wdata, wdata);
                check({name, "_s_wstrb"}, {28'd0, bus.s_wstrb}, {28'd0, wstrb});
            end
            if (bus.m_ready) got = 1'b1;
        end
        check({name, "_got_m_ready"}, {31'd0, got}, 32'd1);
        check({name, "_latency"}, n - 1, exp_lat);
        check({name, "_s_valid_cycles"}, vcyc, exp_vcyc);
        check({name, "_s_valid_slots"}, {28'd0, seen}, {28'd0, exp_mask});
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        bus.m_addr  = '0;
        bus.m_wstrb = '0;
        bus.m_wdata = '0;
        check({name, "_err_count"}, {24'd0, err_count}, {24'd0, exp_err_count});
        check({name, "_err_addr"}, err_addr, exp_err_addr);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_m_ready"}, {31'd0, bus.m_ready}, 32'd0);
        check({name, "_m_rdata"}, bus.m_rdata, 32'd0);
        check({name, "_s_valid"}, {28'd0, bus.s_valid}, 32'd0);
        check({name, "_s_addr"}, bus.s_addr, 32'd0);
        check({name, "_s_wdata"}, bus.s_wdata, 32'd0);
        check({name, "_s_wstrb"}, {28'd0, bus.s_wstrb}, 32'd0);
        check({name, "_err_irq"}, {31'd0, err_irq}, 32'd0);
        check({name, "_err_addr"}, err_addr, 32'd0);
        check({name, "_err_count"}, {24'd0, err_count}, 32'd0);
        check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        bus.m_valid = 1'b0;
        bus.m_addr  = '0;
        bus.m_wstrb = '0;
        bus.m_wdata = '0;
        force_ready = '0;
        for (int i = 0; i < NUM_SLOTS; i++) ready_after[i] = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Read, slot 1, combinational ready.
        do_access("rd_slot1", 32'h0400_0010, 4'h0, 32'h0, 1'b0, 32'h1234_5678, 2, 1, 4'b0010);

        // Write, slot 0, ready after three cycles of s_valid.
        ready_after[0] = 2;
        do_access("wr_slot0", 32'h0300_0000, 4'hF, 32'hA5A5_A5A5, 1'b0, 32'h0BAD_F00D, 4, 3, 4'b0001);

        // Unmapped below and above the slot window.
        do_access("miss_low", 32'h0200_0000, 4'h0, 32'h0, 1'b1, ERR_RDATA, 1, 0, 4'b0000);
        do_access("miss_high", 32'h0700_0000, 4'h0, 32'h0, 1'b1, ERR_RDATA, 1, 0, 4'b0000);
        check("err_count_two_misses", {24'd0, err_count}, 32'd2);
        check("err_addr_second_miss", err_addr, 32'h0700_0000);

        // Timeout on slot 2, then a late ready that must not produce a response.
        ready_after[2] = -1;
        do_access("timeout_slot2", 32'h0500_0004, 4'h0, 32'h0, 1'b1, ERR_RDATA, TO + 1, TO, 4'b0100);
        r = resp_seen;
        force_ready[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        force_ready = '0;
        check("late_ready_no_resp", resp_seen, r);

        // Ready arriving in the timeout cycle wins.
        ready_after[3] = TO - 1;
        do_access("race_slot3", 32'h0600_0008, 4'h0, 32'h0, 1'b0, 32'h3333_3333, TO + 1, TO, 4'b1000);
        check("err_count_after_race", {24'd0, err_count}, 32'd3);

        // Ready on a non-selected slot is ignored.
        ready_after[1] = 2;
        force_ready[3] = 1'b1;
        do_access("ignore_slot3", 32'h0400_0020, 4'h3, 32'h0000_BEEF, 1'b0, 32'h1234_5678, 4, 3, 4'b0010);
        force_ready = '0;

        // Reset in the middle of an access.
        ready_after[2] = -1;
        @(posedge clk); #1;
        bus.m_valid = 1'b1;
        bus.m_addr  = 32'h0500_0000;
        repeat (3) @(negedge clk);
        check("pre_reset_s_valid", {28'd0, bus.s_valid}, 32'h4);
        r = resp_seen;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        bus.m_valid = 1'b0;
        bus.m_addr  = '0;
        exp_err_count = 8'd0;
        exp_err_addr  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        check("reset_no_resp", resp_seen, r);
        ready_after[2] = 0;
        do_access("after_reset", 32'h0500_0000, 4'h0, 32'h0, 1'b0, 32'h2222_2222, 2, 1, 4'b0100);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            do_access("sat_miss", {8'h10, 24'(i)}, 4'h0, 32'h0, 1'b1, ERR_RDATA, 1, 0, 4'b0000);
        end
        check("err_count_saturated", {24'd0, err_count}, 32'd255);
        check("err_addr_last", err_addr, 32'h1000_012B);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iomem_router.md
Name: iomem_router

Overview:
- Sequences the PicoSoC iomem bus: decodes the CPU's iomem request into one of NUM_SLOTS peripheral pages and forwards a registered request to that slot.
- Returns the slot's response to the CPU and guarantees completion: unmapped accesses and peripherals that never assert ready are terminated with an error response.
- Sits between the picosoc iomem port and the peripherals (gpio_led, audio, timer_counter, ...). It replaces the ad-hoc valid gating, ready OR-ing and rdata muxing in the top level.

Parameters:
- NUM_SLOTS, 4: number of peripheral slots, 1..8.
- BASE_PAGE, 8'h03: addr[31:24] of slot 0; slot i decodes page BASE_PAGE+i.
- TIMEOUT_CYCLES, 255: cycles in ACCESS without s_ready before forced termination, 1..255.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on an error termination.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  CPU iomem_valid
- m_ready  out  1  CPU iomem_ready, one-cycle pulse
- m_wstrb  in  4  CPU byte write strobes; 0 = read
- m_addr  in  32  CPU address
- m_wdata  in  32  CPU write data
- m_rdata  out  32  CPU read data, valid while m_ready=1
- s_valid  out  NUM_SLOTS  per-slot request, one-hot or zero
- s_ready  in  NUM_SLOTS  per-slot acknowledge
- s_rdata  in  NUM_SLOTS*32  slot i read data at [32*i+31:32*i]
- s_wstrb  out  4  latched strobes, shared by all slots
- s_addr  out  32  latched address, shared
- s_wdata  out  32  latched write data, shared
- err_irq  out  1  one-cycle pulse on any error termination
- err_addr  out  32  address of the most recent errored access
- err_count  out  8  error count, saturates at 255

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE. All of m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata, err_irq, err_addr, err_count = 0. Timeout counter = 0.
- Reset asserted mid-transaction aborts it: s_valid drops at once and no m_ready is issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Decode: page = m_addr[31:24] - BASE_PAGE, computed in 8-bit unsigned arithmetic. It is a hit iff page < NUM_SLOTS. Addresses below BASE_PAGE wrap to a large value and therefore miss.
- IDLE: when m_valid=1, latch addr/wstrb/wdata into s_addr/s_wstrb/s_wdata and record the slot.
  - Hit: go to ACCESS and set s_valid[slot]=1.
  - Miss: go to ERROR.
- ACCESS: s_valid[slot] held at 1; the counter increments each cycle.
  - s_ready[slot]=1: capture s_rdata[slot] into m_rdata, clear s_valid, clear the counter, go to RESP.
  - Otherwise, when counter reaches TIMEOUT_CYCLES-1: clear s_valid, clear the counter, go to ERROR. s_ready arriving in the same cycle as the timeout wins, so the access goes to RESP.
  - s_ready on non-selected slots is ignored in every state.
- RESP: m_ready=1 for exactly one cycle, m_rdata holds the captured data; then go to IDLE.
- ERROR: m_ready=1, m_rdata=ERR_RDATA and err_irq=1, each for one cycle.
  - err_addr <= latched address; err_count <= err_count+1 unless already 255.
  - Then go to IDLE. Writes to unmapped pages are acknowledged and discarded.
- m_ready is 0 in every state except RESP and ERROR. m_rdata returns to 0 in the cycle after m_ready.
- The master drops m_valid on the clock edge that samples m_ready, so the IDLE cycle following RESP/ERROR does not re-accept the same request.
- Changes to m_valid/m_addr/m_wdata while in ACCESS are ignored; the latched values are used.
- Latency: a hit on a slot that answers combinationally gives m_ready 2 cycles after the cycle in which IDLE sees m_valid. A miss gives m_ready 1 cycle after. A timeout gives m_ready TIMEOUT_CYCLES+1 cycles after.
- s_valid is never asserted for two slots at once.

Test Plan:
- Read, slot 1 (addr 0x0400_0010, s_ready[1] tied 1, s_rdata[1]=0x1234_5678): s_valid=4'b0010 for 1 cycle; m_ready pulses 2 cycles after acceptance with m_rdata=0x1234_5678; err_count stays 0.
- Write, slot 0 (addr 0x0300_0000, wstrb 4'hF, wdata 0xA5A5_A5A5, s_ready[0] after 3 cycles): s_addr/s_wdata/s_wstrb stable throughout; s_valid[0] high 3 cycles; single m_ready pulse.
- Unmapped read at 0x0200_0000 (below BASE_PAGE, wraps) and at 0x0700_0000: m_ready 1 cycle after acceptance with m_rdata=0xFFFF_FFFF; err_irq pulses; err_addr=0x0700_0000 after the second access; err_count=2; no s_valid activity.
- Timeout, TIMEOUT_CYCLES=8, slot 2 never ready: s_valid[2] high exactly 8 cycles, then m_ready with ERR_RDATA and err_irq. s_ready[2] asserted late, after the timeout, produces no second m_ready.
- Race: s_ready asserted in exactly the timeout cycle → normal RESP with slot data; err_count unchanged. s_ready[3]=1 while slot 1 is selected → ignored.
- Reset asserted during ACCESS: s_valid and all outputs 0 immediately, no m_ready. After release, a new hit access completes normally. Run 300 unmapped accesses → err_count saturates at 255.
